// File: rtl/pc_sequencer.sv
// PC sequencer: picks the next PC from halt, branch, jump or sequential fetch.
// Build option PC_SEQ_PENDING_REDIRECT_EN buffers a redirect until the fetch completes.
module pc_sequencer (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] current_pc,
  input  logic        ihit,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        halt,
  output logic [31:0] next_pc,
  output logic        pc_wen,
  output logic        flush,
  output logic        iren,
  output logic        halted,
  output logic        redirect_pending
);

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    REDIR = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_n;
  logic        redir;
  logic [31:0] tgt;
  logic [31:0] seq_pc;

  assign redir  = br_taken | jump;
  assign tgt    = br_taken ? br_target : jump_target;
  assign seq_pc = current_pc + PC_STEP;

`ifdef PC_SEQ_PENDING_REDIRECT_EN
  logic [31:0] pend_target;
  logic [31:0] pend_n;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= RUN;
      pend_target <= 32'd0;
    end else begin
      state       <= state_n;
      pend_target <= pend_n;
    end
  end
`else
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= RUN;
    end else begin
      state <= state_n;
    end
  end
`endif

  always_comb begin
    state_n          = state;
    next_pc          = seq_pc;
    pc_wen           = 1'b0;
    flush            = 1'b0;
    iren             = 1'b0;
    halted           = 1'b0;
    redirect_pending = 1'b0;
`ifdef PC_SEQ_PENDING_REDIRECT_EN
    pend_n           = pend_target;
`endif
    if (!RST) begin
      unique case (state)
        RUN: begin
          iren = 1'b1;
          if (halt) begin
            state_n = HALT;
          end else if (redir) begin
            flush   = 1'b1;
            next_pc = tgt;
`ifdef PC_SEQ_PENDING_REDIRECT_EN
            if (ihit) begin
              pc_wen = 1'b1;
            end else begin
              pend_n  = tgt;
              state_n = REDIR;
            end
`else
            pc_wen = 1'b1;
`endif
          end else begin
            pc_wen = ihit & ~stall;
          end
        end
`ifdef PC_SEQ_PENDING_REDIRECT_EN
        REDIR: begin
          iren             = 1'b1;
          redirect_pending = 1'b1;
          next_pc          = pend_target;
          if (halt) begin
            state_n = HALT;
          end else if (redir) begin
            // a newer redirect overrides the one still waiting
            flush  = 1'b1;
            pend_n = tgt;
            if (ihit) begin
              next_pc = tgt;
              pc_wen  = 1'b1;
              state_n = RUN;
            end
          end else if (ihit) begin
            pc_wen  = 1'b1;
            state_n = RUN;
          end
        end
`endif
        HALT: begin
          halted = 1'b1;
        end
        default: begin
          state_n = RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: behavioural model checked every cycle plus directed literals.
// Works with or without PC_SEQ_PENDING_REDIRECT_EN defined.
module tb_pc_sequencer;

`ifdef PC_SEQ_PENDING_REDIRECT_EN
  localparam bit PEND_EN = 1'b1;
`else
  localparam bit PEND_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] current_pc = '0;
  logic        ihit = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        halt = 1'b0;
  logic [31:0] next_pc;
  logic        pc_wen;
  logic        flush;
  logic        iren;
  logic        halted;
  logic        redirect_pending;

  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;

  pc_sequencer dut (
    .CLK(CLK),
    .RST(RST),
    .current_pc(current_pc),
    .ihit(ihit),
    .stall(stall),
    .br_taken(br_taken),
    .br_target(br_target),
    .jump(jump),
    .jump_target(jump_target),
    .halt(halt),
    .next_pc(next_pc),
    .pc_wen(pc_wen),
    .flush(flush),
    .iren(iren),
    .halted(halted),
    .redirect_pending(redirect_pending)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // model: sequencer is either halted, waiting on a redirect, or running
  bit          m_halt = 1'b0;
  bit          m_pend = 1'b0;
  logic [31:0] m_tgt  = '0;
  bit          n_halt;
  bit          n_pend;
  logic [31:0] n_tgt;

  always @(negedge CLK) begin
    logic [31:0] e_npc;
    logic [31:0] tgt;
    logic e_wen, e_fl, e_iren, e_hlt, e_rp;
    bit npc_chk;
    e_npc = current_pc + 32'd4;
    tgt = br_taken ? br_target : jump_target;
    e_wen = 0; e_fl = 0; e_iren = 0; e_hlt = 0; e_rp = 0;
    npc_chk = 1;
    n_halt = m_halt; n_pend = m_pend; n_tgt = m_tgt;
    if (RST) begin
      n_halt = 0; n_pend = 0; n_tgt = '0;
    end else if (m_halt) begin
      e_hlt = 1; npc_chk = 0;
    end else begin
      e_iren = 1;
      e_rp = m_pend;
      if (halt) begin
        npc_chk = 0; n_halt = 1; n_pend = 0;
      end else if (br_taken || jump) begin
        e_fl = 1;
        if (ihit || !PEND_EN) begin
          e_wen = 1; e_npc = tgt; n_pend = 0;
        end else begin
          npc_chk = 0; n_pend = 1; n_tgt = tgt;
        end
      end else if (m_pend) begin
        e_npc = m_tgt; e_wen = ihit;
        if (ihit) n_pend = 0;
      end else begin
        e_wen = ihit & ~stall;
      end
    end
    if (armed) begin
      if (npc_chk) chk("m_next_pc", next_pc, e_npc);
      chk("m_pc_wen", {31'd0, pc_wen}, {31'd0, e_wen});
      chk("m_flush", {31'd0, flush}, {31'd0, e_fl});
      chk("m_iren", {31'd0, iren}, {31'd0, e_iren});
      chk("m_halted", {31'd0, halted}, {31'd0, e_hlt});
      chk("m_redir_pend", {31'd0, redirect_pending}, {31'd0, e_rp});
    end
  end

  always @(posedge CLK) begin
    m_halt <= n_halt;
    m_pend <= n_pend;
    m_tgt  <= n_tgt;
  end

  task automatic cyc(input logic r, input logic [31:0] cpc, input logic ih,
                     input logic st, input logic bt, input logic [31:0] btg,
                     input logic jp, input logic [31:0] jtg, input logic hl);
    @(posedge CLK);
    #1;
    RST = r; current_pc = cpc; ihit = ih; stall = st;
    br_taken = bt; br_target = btg; jump = jp; jump_target = jtg; halt = hl;
    @(negedge CLK);
    #1;
  endtask

  initial begin
    cyc(1, 32'h0, 1, 0, 0, 0, 0, 0, 0);
    armed = 1'b1;
    cyc(1, 32'h0, 1, 0, 0, 0, 0, 0, 0);
    chk("rst_next_pc", next_pc, 32'h4);
    chk("rst_pc_wen", {31'd0, pc_wen}, 32'd0);
    chk("rst_iren", {31'd0, iren}, 32'd0);

    cyc(0, 32'h0, 1, 0, 0, 0, 0, 0, 0);
    chk("first_next_pc", next_pc, 32'h4);
    chk("first_pc_wen", {31'd0, pc_wen}, 32'd1);
    chk("first_iren", {31'd0, iren}, 32'd1);

    cyc(0, 32'h40, 1, 1, 0, 0, 0, 0, 0);
    chk("stall_pc_wen", {31'd0, pc_wen}, 32'd0);
    cyc(0, 32'h40, 1, 1, 1, 32'h100, 0, 0, 0);
    chk("br_next_pc", next_pc, 32'h100);
    chk("br_pc_wen", {31'd0, pc_wen}, 32'd1);
    chk("br_flush", {31'd0, flush}, 32'd1);

    cyc(0, 32'h100, 1, 0, 1, 32'h300, 1, 32'h400, 0);
    chk("prio_next_pc", next_pc, 32'h300);
    cyc(0, 32'h100, 1, 0, 0, 0, 1, 32'h400, 0);
    chk("jump_next_pc", next_pc, 32'h400);

    cyc(0, 32'hFFFF_FFFC, 1, 0, 0, 0, 0, 0, 0);
    chk("wrap_next_pc", next_pc, 32'h0);
    cyc(0, 32'h8, 0, 0, 0, 0, 0, 0, 0);
    chk("nohit_pc_wen", {31'd0, pc_wen}, 32'd0);

    if (PEND_EN) begin
      cyc(0, 32'h10, 0, 0, 0, 0, 1, 32'h200, 0);
      chk("pend_flush", {31'd0, flush}, 32'd1);
      chk("pend_pc_wen", {31'd0, pc_wen}, 32'd0);
      cyc(0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
      chk("pend_flag", {31'd0, redirect_pending}, 32'd1);
      cyc(0, 32'h10, 1, 1, 0, 0, 0, 0, 0);
      chk("pend_next_pc", next_pc, 32'h200);
      chk("pend_pc_wen_hit", {31'd0, pc_wen}, 32'd1);
      cyc(0, 32'h200, 1, 0, 0, 0, 0, 0, 0);
      chk("pend_back_run", {31'd0, redirect_pending}, 32'd0);
      chk("pend_seq_pc", next_pc, 32'h204);
      cyc(0, 32'h20, 0, 0, 0, 0, 1, 32'h500, 0);
      cyc(0, 32'h20, 0, 0, 1, 32'h600, 0, 0, 0);
      chk("repend_flush", {31'd0, flush}, 32'd1);
      cyc(0, 32'h20, 1, 0, 0, 0, 0, 0, 0);
      chk("repend_next_pc", next_pc, 32'h600);
      cyc(0, 32'h20, 0, 0, 1, 32'h700, 0, 0, 0);
      cyc(0, 32'h20, 1, 0, 0, 0, 1, 32'h780, 0);
      chk("redir_hit_new", next_pc, 32'h780);
      cyc(0, 32'h30, 0, 0, 0, 0, 1, 32'h900, 0);
      cyc(1, 32'h30, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_redir_clear", {31'd0, redirect_pending}, 32'd0);
      cyc(0, 32'h30, 1, 0, 0, 0, 0, 0, 0);
      chk("rst_redir_seq", next_pc, 32'h34);
      cyc(0, 32'h40, 0, 0, 0, 0, 1, 32'hA00, 0);
      cyc(0, 32'h40, 1, 0, 1, 32'hB00, 0, 0, 1);
      chk("redir_halt_wen", {31'd0, pc_wen}, 32'd0);
      cyc(0, 32'h40, 1, 0, 0, 0, 0, 0, 0);
      chk("redir_halt_sticky", {31'd0, halted}, 32'd1);
      cyc(1, 32'h40, 1, 0, 0, 0, 0, 0, 0);
    end else begin
      cyc(0, 32'h10, 0, 0, 1, 32'h80, 0, 0, 0);
      chk("np_next_pc", next_pc, 32'h80);
      chk("np_pc_wen", {31'd0, pc_wen}, 32'd1);
      chk("np_redir_pend", {31'd0, redirect_pending}, 32'd0);
    end

    cyc(0, 32'h50, 1, 0, 1, 32'h123, 0, 0, 1);
    chk("halt_pc_wen", {31'd0, pc_wen}, 32'd0);
    chk("halt_flush", {31'd0, flush}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 32'h50 + 32'(i * 4), 1, 0, i[0], 32'h44, i[1], 32'h88, i[2]);
      chk("halted_wen", {31'd0, pc_wen}, 32'd0);
      chk("halted_flag", {31'd0, halted}, 32'd1);
    end
    cyc(1, 32'h60, 1, 0, 0, 0, 0, 0, 0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    cyc(0, 32'h60, 1, 0, 0, 0, 0, 0, 0);
    chk("resume_wen", {31'd0, pc_wen}, 32'd1);
    chk("resume_next_pc", next_pc, 32'h64);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] r;
      r = $urandom;
      cyc(0, $urandom & 32'hFFFF_FFFC, r[0], r[1], r[2] & r[3],
          $urandom, r[4] & r[5], $urandom, (i == 35) ? 1'b1 : 1'b0);
    end
    cyc(1, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 32'h0, 1, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are listed below with clock and reset first.
REQ-002 PC_STEP, 32'd4, sequential fetch increment.
REQ-003 CLK  in  1  rising-edge clock.
REQ-004 RST  in  1  asynchronous active-high reset.
REQ-005 current_pc  in  32  present PC-register value.
REQ-006 ihit  in  1  instruction fetch for current_pc completes this cycle.
REQ-007 stall  in  1  hazard-unit hold on sequential advance.
REQ-008 br_taken  in  1  resolved taken branch this cycle.
REQ-009 br_target  in  32  branch target.
REQ-010 jump  in  1  jump (J/JAL/JR) resolved this cycle.
REQ-011 jump_target  in  32  jump target.
REQ-012 halt  in  1  HALT instruction retired.
REQ-013 next_pc  out  32  value for the PC register.
REQ-014 pc_wen  out  1  PC-register write enable.
REQ-015 flush  out  1  squash IF/ID contents.
REQ-016 iren  out  1  instruction-fetch request.
REQ-017 halted  out  1  sequencer halted.
REQ-018 redirect_pending  out  1  a captured target is waiting for ihit.

Function
REQ-019 States SHALL be RUN, REDIR and HALT; registered state and pend_target (32 bits) only.
REQ-020 Request priority SHALL be halt > br_taken > jump > sequential; br_target is used when br_taken and jump are both high.
REQ-021 RUN, no halt/redirect: next_pc = current_pc + PC_STEP modulo 2^32 (0xFFFFFFFC+4 = 0x00000000); pc_wen = ihit & ~stall; flush = 0.
REQ-022 RUN, redirect with ihit=1: next_pc = target, pc_wen = 1, flush = 1 the same cycle, regardless of stall; stay RUN.
REQ-023 RUN, redirect with ihit=0: pc_wen = 0, flush = 1, pend_target <= target, go REDIR.
REQ-024 REDIR: next_pc = pend_target; pc_wen = ihit; on ihit go RUN; stall is ignored.
REQ-025 REDIR, new redirect: pend_target <= new target, flush = 1. With ihit=1, next_pc = new target and pc_wen = 1, then go RUN.
REQ-026 halt in RUN or REDIR SHALL give pc_wen = 0 and flush = 0 that cycle and go HALT; any concurrent redirect or pending target is discarded.
REQ-027 HALT SHALL be sticky until reset: pc_wen = 0, iren = 0, flush = 0, halted = 1; all inputs are ignored.
REQ-028 iren SHALL be 1 in RUN and REDIR; redirect_pending SHALL be 1 only in REDIR.
REQ-029 next_pc, pc_wen and flush SHALL be combinational from state, pend_target and inputs, with zero-cycle latency.

Reset
REQ-030 RST high SHALL immediately force state = RUN and pend_target = 0, independent of CLK.
REQ-031 During reset: pc_wen = 0, flush = 0, iren = 0, halted = 0, redirect_pending = 0, next_pc = current_pc + PC_STEP.
REQ-032 Reset in REDIR or HALT SHALL discard the pending target and halt status; fetch resumes in RUN on the first edge after RST falls.

Configuration
REQ-033 Macro PC_SEQ_PENDING_REDIRECT_EN SHALL select redirect buffering.
REQ-034 Defined: REQ-023 to REQ-025 apply as written.
REQ-035 Undefined: REDIR and pend_target do not exist; redirect_pending is tied 0; any RUN redirect gives next_pc = target, pc_wen = 1, flush = 1 regardless of ihit; the icache tolerates an address change mid-fetch.

Verification
REQ-036 Reset, then current_pc=0x0, ihit=1, stall=0 -> next_pc=0x4, pc_wen=1, iren=1 on the first cycle after RST falls.
REQ-037 current_pc=0x40, ihit=1, stall=1 -> pc_wen=0; same cycle with br_taken=1, br_target=0x100 -> next_pc=0x100, pc_wen=1, flush=1.
REQ-038 (Macro on) ihit=0, jump=1, jump_target=0x200 -> flush=1, redirect_pending=1 next cycle; ihit=1 two cycles later -> next_pc=0x200, pc_wen=1, then state RUN.
REQ-039 br_taken=1 (0x300) and jump=1 (0x400) in the same cycle with ihit=1 -> next_pc=0x300.
REQ-040 halt=1 with br_taken=1 -> pc_wen=0, flush=0, halted=1 from the next edge; 10 cycles of ihit=1 -> pc_wen stays 0; RST pulse -> halted=0.
REQ-041 current_pc=0xFFFFFFFC, ihit=1 -> next_pc=0x00000000; (macro off) ihit=0, br_taken=1, br_target=0x80 -> pc_wen=1, next_pc=0x80, redirect_pending=0.
